// File: rtl/npu_feed_pkg.sv
// Shared types for the price-feed to NPU feature path: price width, signed delta,
// fill-state encoding and the 9-bit to 8-bit delta saturation helper.
package npu_feed_pkg;

    localparam int PRICE_W = 8;

    typedef logic signed [7:0] delta_t;

    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } fill_state_t;

    // Clamp a 9-bit signed difference into the signed 8-bit range [-128, 127].
    function automatic delta_t sat_delta(input logic signed [8:0] d9);
        delta_t res;
        case (d9[8:7])
            2'b01:   res = 8'sh7F;
            2'b10:   res = 8'sh80;
            default: res = d9[7:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tick_delta_sat.sv
// Combinational tick-to-tick price difference, saturated to a signed 8-bit delta.
module tick_delta_sat
    import npu_feed_pkg::*;
(
    input  logic [PRICE_W-1:0] price,
    input  logic [PRICE_W-1:0] prev_price,
    output delta_t             delta
);

    logic signed [8:0] d9;

    assign d9    = {1'b0, price} - {1'b0, prev_price};
    assign delta = sat_delta(d9);

endmodule

// File: rtl/tick_window_builder.sv
// Turns single-cycle price pulses into a sliding window of saturated deltas and
// streams it to the NPU over valid/ready, absorbing stalls and counting dropped snapshots.
module tick_window_builder
    import npu_feed_pkg::*;
#(
    parameter int WINDOW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRICE_W-1:0]    price_in,
    input  logic                  price_valid,
    input  logic                  flush,
    output logic [WINDOW*8-1:0]   m_feat_tdata,
    output logic [PRICE_W-1:0]    m_feat_tuser,
    output logic                  m_feat_tvalid,
    input  logic                  m_feat_tready,
    output logic [CNT_W-1:0]      overrun_cnt,
    output fill_state_t           state_dbg
);

    // Stream handshake: a vector transfers on a clock edge where m_feat_tvalid and
    // m_feat_tready are both 1; while tvalid=1 and tready=0, tdata/tuser stay stable.

    localparam int             FC_W      = 5;
    localparam logic [FC_W-1:0] FILL_LAST = FC_W'(WINDOW - 1);

    fill_state_t          state_q, state_next;
    logic [FC_W-1:0]      fill_cnt_q;
    logic [PRICE_W-1:0]   prev_q;
    logic [WINDOW*8-1:0]  window_q;
    logic [WINDOW*8-1:0]  window_next;
    logic                 pending_q;
    delta_t               delta;
    logic                 prime, push, load_evt;

    tick_delta_sat u_delta (
        .price      (price_in),
        .prev_price (prev_q),
        .delta      (delta)
    );

    assign window_next = {window_q[WINDOW*8-9:0], delta};
    assign state_dbg   = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= PRIME;
        else        state_q <= state_next;
    end

    // Flush overrides any coincident tick, so the tick never reaches the window.
    always_comb begin
        state_next = state_q;
        prime      = 1'b0;
        push       = 1'b0;
        load_evt   = 1'b0;
        if (flush) begin
            state_next = PRIME;
        end else if (price_valid) begin
            case (state_q)
                PRIME: begin
                    prime      = 1'b1;
                    state_next = FILL;
                end
                FILL: begin
                    push = 1'b1;
                    if (fill_cnt_q == FILL_LAST) begin
                        state_next = STREAM;
                        load_evt   = 1'b1;
                    end
                end
                STREAM: begin
                    push     = 1'b1;
                    load_evt = 1'b1;
                end
                default: state_next = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt_q    <= '0;
            prev_q        <= '0;
            window_q      <= '0;
            pending_q     <= 1'b0;
            m_feat_tdata  <= '0;
            m_feat_tuser  <= '0;
            m_feat_tvalid <= 1'b0;
            overrun_cnt   <= '0;
        end else if (flush) begin
            fill_cnt_q    <= '0;
            prev_q        <= '0;
            window_q      <= '0;
            pending_q     <= 1'b0;
            m_feat_tdata  <= '0;
            m_feat_tuser  <= '0;
            m_feat_tvalid <= 1'b0;
        end else begin
            if (prime) prev_q <= price_in;
            if (push) begin
                window_q <= window_next;
                prev_q   <= price_in;
                if (state_q == FILL) fill_cnt_q <= fill_cnt_q + 1'b1;
            end
            if (load_evt) begin
                if (!m_feat_tvalid || m_feat_tready) begin
                    m_feat_tdata  <= window_next;
                    m_feat_tuser  <= price_in;
                    m_feat_tvalid <= 1'b1;
                    pending_q     <= 1'b0;
                end else begin
                    // A second unsent snapshot overwrites the first pending one.
                    if (pending_q && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + 1'b1;
                    pending_q <= 1'b1;
                end
            end else if (m_feat_tvalid && m_feat_tready) begin
                if (pending_q) begin
                    m_feat_tdata <= window_q;
                    m_feat_tuser <= prev_q;
                    pending_q    <= 1'b0;
                end else begin
                    m_feat_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_window_builder.sv
// Directed bench for tick_window_builder (WINDOW=4): priming, saturation, stall/overrun,
// simultaneous tick+handshake, flush and mid-stream reset.
module tb_tick_window_builder;
    import npu_feed_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [7:0]        price_in;
    logic              price_valid;
    logic              flush;
    logic [31:0]       m_feat_tdata;
    logic [7:0]        m_feat_tuser;
    logic              m_feat_tvalid;
    logic              m_feat_tready;
    logic [15:0]       overrun_cnt;
    fill_state_t       state_dbg;

    int n_vec = 0;
    int n_err = 0;

    tick_window_builder #(.WINDOW(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .price_in      (price_in),
        .price_valid   (price_valid),
        .flush         (flush),
        .m_feat_tdata  (m_feat_tdata),
        .m_feat_tuser  (m_feat_tuser),
        .m_feat_tvalid (m_feat_tvalid),
        .m_feat_tready (m_feat_tready),
        .overrun_cnt   (overrun_cnt),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] p);
        price_valid = 1'b1;
        price_in    = p;
        @(posedge clk);
        #1;
        price_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; price_in = '0; price_valid = 1'b0; flush = 1'b0; m_feat_tready = 1'b1;
        idle(); idle();
        chk("rst_tvalid", 32'(m_feat_tvalid), 32'd0);
        chk("rst_tdata",  m_feat_tdata, 32'h0);
        chk("rst_tuser",  32'(m_feat_tuser), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_state",  32'(state_dbg), 32'(PRIME));
        rst_n = 1'b1;

        // 1: prime and fill
        tick(8'd100);
        chk("prime_state", 32'(state_dbg), 32'(FILL));
        chk("prime_tvalid", 32'(m_feat_tvalid), 32'd0);
        tick(8'd101); tick(8'd103); tick(8'd106);
        chk("fill_tvalid", 32'(m_feat_tvalid), 32'd0);
        tick(8'd110);
        chk("first_tvalid", 32'(m_feat_tvalid), 32'd1);
        chk("first_tdata",  m_feat_tdata, 32'h01020304);
        chk("first_tuser",  32'(m_feat_tuser), 32'd110);
        chk("first_state",  32'(state_dbg), 32'(STREAM));
        idle();
        chk("hs_drop_tvalid", 32'(m_feat_tvalid), 32'd0);

        // 2: saturation
        tick(8'd0);
        chk("neg_tdata", m_feat_tdata, 32'h02030492);
        tick(8'd255);
        chk("sat_pos_tdata", m_feat_tdata, 32'h0304927F);
        chk("sat_pos_tuser", 32'(m_feat_tuser), 32'hFF);
        tick(8'd0);
        chk("sat_neg_tdata", m_feat_tdata, 32'h04927F80);
        idle();
        chk("sat_drop_tvalid", 32'(m_feat_tvalid), 32'd0);

        // 3: stall
        m_feat_tready = 1'b0;
        tick(8'd10);
        chk("stall_load_tdata", m_feat_tdata, 32'h927F800A);
        tick(8'd12);
        chk("stall1_overrun", 32'(overrun_cnt), 32'd0);
        tick(8'd15);
        chk("stall2_overrun", 32'(overrun_cnt), 32'd1);
        tick(8'd20);
        chk("stall3_overrun", 32'(overrun_cnt), 32'd2);
        chk("stall_held_tdata", m_feat_tdata, 32'h927F800A);
        chk("stall_held_tuser", 32'(m_feat_tuser), 32'h0A);
        chk("stall_tvalid", 32'(m_feat_tvalid), 32'd1);
        m_feat_tready = 1'b1;
        idle();
        chk("pend_tvalid", 32'(m_feat_tvalid), 32'd1);
        chk("pend_tdata",  m_feat_tdata, 32'h0A020305);
        chk("pend_tuser",  32'(m_feat_tuser), 32'd20);
        idle();
        chk("pend_drop_tvalid", 32'(m_feat_tvalid), 32'd0);

        // 4: tick and handshake together
        tick(8'd22);
        chk("simul_pre_tdata", m_feat_tdata, 32'h02030502);
        tick(8'd21);
        chk("simul_tvalid",  32'(m_feat_tvalid), 32'd1);
        chk("simul_tdata",   m_feat_tdata, 32'h030502FF);
        chk("simul_overrun", 32'(overrun_cnt), 32'd2);
        idle();

        // 5: flush while held
        m_feat_tready = 1'b0;
        tick(8'd30);
        chk("fl_pre_tdata", m_feat_tdata, 32'h0502FF09);
        tick(8'd31);
        flush = 1'b1;
        idle();
        flush = 1'b0;
        chk("flush_tvalid",  32'(m_feat_tvalid), 32'd0);
        chk("flush_state",   32'(state_dbg), 32'(PRIME));
        chk("flush_overrun", 32'(overrun_cnt), 32'd2);
        flush = 1'b1;
        tick(8'd99);
        flush = 1'b0;
        chk("flush_tick_state", 32'(state_dbg), 32'(PRIME));
        m_feat_tready = 1'b1;
        tick(8'd50);
        chk("reprime_tvalid", 32'(m_feat_tvalid), 32'd0);
        chk("reprime_state",  32'(state_dbg), 32'(FILL));
        tick(8'd51); tick(8'd52); tick(8'd53);
        chk("refill_tvalid", 32'(m_feat_tvalid), 32'd0);
        tick(8'd54);
        chk("refill_tvalid2", 32'(m_feat_tvalid), 32'd1);
        chk("refill_tdata",   m_feat_tdata, 32'h01010101);
        chk("refill_tuser",   32'(m_feat_tuser), 32'd54);

        // 6: reset mid-stream with a coincident tick
        rst_n = 1'b0;
        tick(8'd200);
        rst_n = 1'b1;
        chk("mrst_tvalid",  32'(m_feat_tvalid), 32'd0);
        chk("mrst_tdata",   m_feat_tdata, 32'h0);
        chk("mrst_tuser",   32'(m_feat_tuser), 32'd0);
        chk("mrst_overrun", 32'(overrun_cnt), 32'd0);
        chk("mrst_state",   32'(state_dbg), 32'(PRIME));
        tick(8'd60); tick(8'd61); tick(8'd62); tick(8'd63);
        chk("restart_tvalid", 32'(m_feat_tvalid), 32'd0);
        tick(8'd64);
        chk("restart_tvalid2", 32'(m_feat_tvalid), 32'd1);
        chk("restart_tdata",   m_feat_tdata, 32'h01010101);
        chk("restart_tuser",   32'(m_feat_tuser), 32'd64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
